// File: rtl/alu_pkg.sv
// Shared definitions for the nibble-serial ALU sequencer: opcodes, FSM states
// and the slice width.
package alu_pkg;

    localparam int NIBBLE_W = 4;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_AND  = 3'b001;
    localparam logic [2:0] OP_OR   = 3'b010;
    localparam logic [2:0] OP_NAND = 3'b011;
    localparam logic [2:0] OP_NOR  = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

    // Opcodes above NOR have no defined operation.
    function automatic logic is_reserved(input logic [2:0] op);
        return op > OP_NOR;
    endfunction

endpackage

// File: rtl/alu_nibble_slice.sv
// Combinational 4-bit ALU slice. It also exposes the carry into bit 3 so the
// engine can derive signed overflow on the most significant nibble.
module alu_nibble_slice
    import alu_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a_i,
    input  logic [NIBBLE_W-1:0] b_i,
    input  logic                cin_i,
    input  logic [2:0]          op_i,
    output logic [NIBBLE_W-1:0] out_o,
    output logic                cout_o,
    output logic                c3_o
);

    logic [NIBBLE_W:0]   sum;
    logic [NIBBLE_W-1:0] low_sum;

    assign sum     = {1'b0, a_i} + {1'b0, b_i} + {{NIBBLE_W{1'b0}}, cin_i};
    assign low_sum = {1'b0, a_i[2:0]} + {1'b0, b_i[2:0]} + {{(NIBBLE_W-1){1'b0}}, cin_i};

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        out_o  = '0;
        cout_o = 1'b0;
        c3_o   = 1'b0;
        case (op_i)
            OP_ADD: begin
                out_o  = sum[NIBBLE_W-1:0];
                cout_o = sum[NIBBLE_W];
                c3_o   = low_sum[NIBBLE_W-1];
            end
            OP_AND:  out_o = a_i & b_i;
            OP_OR:   out_o = a_i | b_i;
            OP_NAND: out_o = ~(a_i & b_i);
            OP_NOR:  out_o = ~(a_i | b_i);
            default: out_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq_engine.sv
// Nibble-serial ALU sequencer: one 4-bit slice per cycle, LSB first, with
// valid/ready request and response channels. Define ALU_SEQ_OVF_EN for rsp_ovf.
module alu_seq_engine
    import alu_pkg::*;
#(
    parameter int NIBBLES = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [2:0]                req_op,
    input  logic [NIBBLE_W*NIBBLES-1:0] req_a,
    input  logic [NIBBLE_W*NIBBLES-1:0] req_b,
    input  logic                      req_cin,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [NIBBLE_W*NIBBLES-1:0] rsp_result,
    output logic                      rsp_cout,
    output logic                      rsp_zero,
    output logic                      busy
`ifdef ALU_SEQ_OVF_EN
    ,
    output logic                      rsp_ovf
`endif
);

    localparam int WIDTH = NIBBLE_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               cout_q, cout_d;
    logic               zero_q, zero_d;
`ifdef ALU_SEQ_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    logic [NIBBLE_W-1:0] slice_a, slice_b, slice_out;
    logic                slice_cout, slice_c3;
    logic                last_nibble;

    // Nibble base is idx*4, formed by concatenation since NIBBLE_W is 4.
    assign slice_a     = a_q[{idx_q, 2'b00} +: NIBBLE_W];
    assign slice_b     = b_q[{idx_q, 2'b00} +: NIBBLE_W];
    assign last_nibble = (idx_q == IDX_W'(NIBBLES - 1));

    alu_nibble_slice u_slice (
        .a_i    (slice_a),
        .b_i    (slice_b),
        .cin_i  (carry_q),
        .op_i   (op_q),
        .out_o  (slice_out),
        .cout_o (slice_cout),
        .c3_o   (slice_c3)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        cout_d   = cout_q;
        zero_d   = zero_q;
`ifdef ALU_SEQ_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    op_d     = req_op;
                    a_d      = req_a;
                    b_d      = req_b;
                    carry_d  = req_cin;
                    idx_d    = '0;
                    result_d = '0;
                    cout_d   = 1'b0;
                    zero_d   = 1'b0;
`ifdef ALU_SEQ_OVF_EN
                    ovf_d    = 1'b0;
`endif
                    state_d  = S_EXEC;
                end
            end
            S_EXEC: begin
                result_d[{idx_q, 2'b00} +: NIBBLE_W] = slice_out;
                // Slice returns carry 0 for non-ADD ops, so the chain self-clears.
                carry_d = slice_cout;
                if (last_nibble) begin
                    cout_d  = slice_cout;
                    zero_d  = (result_d == '0);
`ifdef ALU_SEQ_OVF_EN
                    ovf_d   = is_reserved(op_q) ||
                              ((op_q == OP_ADD) && (slice_c3 ^ slice_cout));
`endif
                    state_d = S_RESP;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            zero_q   <= zero_d;
`ifdef ALU_SEQ_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign req_ready  = (state_q == S_IDLE) && rst_n;
    assign rsp_valid  = (state_q == S_RESP);
    assign busy       = (state_q != S_IDLE);
    assign rsp_result = result_q;
    assign rsp_cout   = cout_q;
    assign rsp_zero   = zero_q;
`ifdef ALU_SEQ_OVF_EN
    assign rsp_ovf    = ovf_q;
`endif

endmodule

// File: doc/alu_seq_engine.md
Name: alu_seq_engine

Overview:
Multi-cycle sequencer for the 4-bit ALU datapath. It accepts a WIDTH-bit operation over a valid/ready request channel and processes it one nibble per cycle, LSB first, chaining carry between nibbles. It then returns the result, carry and zero flag over a valid/ready response channel. The block sits between the control path and the 4-bit execute datapath, so operands wider than 4 bits can use the same opcode set.

Parameters:
NIBBLES, 2, number of 4-bit slices per operation; WIDTH = 4*NIBBLES; legal range 1..8

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request
req_op  input  3  opcode: 000 ADD, 001 AND, 010 OR, 011 NAND, 100 NOR, 101/110/111 reserved
req_a  input  WIDTH  operand A
req_b  input  WIDTH  operand B
req_cin  input  1  carry-in, used by ADD only
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_result  output  WIDTH  operation result
rsp_cout  output  1  carry-out of MSB nibble (ADD only, else 0)
rsp_zero  output  1  rsp_result == 0
busy  output  1  state != IDLE

Behaviour:
- Reset: clk is the single clock. rst_n is asynchronous and active-low.
  - Asserting rst_n forces state IDLE, nibble index 0 and carry register 0.
  - rsp_valid, rsp_result, rsp_cout, rsp_zero and busy all reset to 0.
  - req_ready = (state == IDLE) & rst_n, so it is 0 while reset is held.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready, latch op, a, b and cin (cin goes into the carry register).
  - Clear the index, clear the result register, go to EXEC.
- EXEC, one cycle per nibble i = index:
  - Compute the slice per opcode on a[4i+3:4i] and b[4i+3:4i].
  - ADD uses the carry register as carry-in. The 5-bit sum gives result nibble i and the new carry.
  - Logic ops produce the bitwise result and leave the carry at 0.
  - Reserved ops write nibble 0000.
  - When i == NIBBLES-1, go to RESP; otherwise increment the index.
- RESP:
  - rsp_valid = 1.
  - rsp_cout = final carry for ADD, 0 for all other ops.
  - rsp_zero is registered with the result.
  - Outputs are held stable until rsp_ready is sampled high, then go to IDLE with rsp_valid deasserting next cycle.
- Latency:
  - The accept edge is cycle 0; rsp_valid is asserted from cycle NIBBLES+1.
  - Minimum issue interval is NIBBLES+2 cycles, because req_ready is low in EXEC and RESP.
- Request inputs are ignored outside IDLE. Latched operands are immune to input changes during EXEC.
- A simultaneous rsp_ready and new req_valid in RESP does not accept the request; it is accepted in the following IDLE cycle.
- rsp_ready is a don't-care outside RESP.
- Reset mid-EXEC or mid-RESP aborts the operation and discards the response. The first request after rst_n releases executes normally.
- Arithmetic is unsigned and modulo 2^WIDTH, with the carry out of the MSB on rsp_cout.

Optional Feature:
ALU_SEQ_OVF_EN:
- When defined: adds output port rsp_ovf (1 bit), the two's-complement overflow of ADD.
  - rsp_ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - It is 0 for non-ADD ops, valid with rsp_valid, and reset to 0.
  - Reserved opcodes also raise rsp_ovf as an illegal-op indication.
- When undefined: the port and its logic are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package alu_pkg holds:
  - opcode constants OP_ADD=3'b000, OP_AND=3'b001, OP_OR=3'b010, OP_NAND=3'b011, OP_NOR=3'b100;
  - FSM state encodings S_IDLE, S_EXEC, S_RESP;
  - NIBBLE_W = 4.
- One sub-module: alu_nibble_slice. It is combinational and takes a[3:0], b[3:0], cin and op[2:0]; it produces out[3:0], cout and the carry into bit 3 (used for overflow).
- The engine instantiates alu_nibble_slice once and time-multiplexes it across nibbles.

Test Plan:
All scenarios use NIBBLES=2.
1. ADD a=0x3C b=0xC5 cin=0 -> rsp_result=0x01, rsp_cout=1, rsp_zero=0; rsp_valid first high exactly 3 cycles after the accept edge.
2. ADD a=0xFF b=0x00 cin=1 -> rsp_result=0x00, rsp_cout=1, rsp_zero=1. This checks carry propagation across the nibble boundary.
3. Logic ops, each with rsp_cout=0:
   - NAND a=0xF0 b=0xFF -> rsp_result=0x0F;
   - NOR a=0x0F b=0x30 -> rsp_result=0xC0;
   - AND a=0xA5 b=0x0F -> 0x05;
   - OR a=0xA0 b=0x05 -> 0xA5.
4. Backpressure: hold rsp_ready=0 for 5 cycles in RESP while pulsing req_valid with new operands -> response held stable, req_ready=0, new request not accepted. Release rsp_ready -> the new request is accepted one cycle after rsp_valid falls and completes correctly.
5. Reset mid-EXEC: assert rst_n=0 one cycle after accept -> all outputs 0 immediately. After release, ADD 0x12+0x34 -> 0x46, cout 0.
6. Reserved op 3'b110 a=0xFF b=0xFF -> rsp_result=0x00, rsp_cout=0, rsp_zero=1. With ALU_SEQ_OVF_EN:
   - the reserved op sets rsp_ovf=1;
   - ADD 0x7F+0x01 -> 0x80, rsp_ovf=1;
   - ADD 0x10+0x01 -> rsp_ovf=0.
